stopwatch_ctrl: RTL

Hardware sequencer for the six-digit stopwatch display. Debounces the push-button and samples the 2-bit mode switch. Runs a start/pause/lap/clear state machine and a centisecond timebase. Drives six BCD digits (mm:ss.cc) that feed the existing per-digit 7-segment decoders in place of the software-written PIO registers.

---
 rtl/stopwatch_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button synchronizer and debouncer, start/pause/lap/clear
// state machine, centisecond prescaler and a six-digit BCD mm:ss.cc counter
// with a registered display mux feeding the 7-segment decoders.
module stopwatch_ctrl #(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned TICK_HZ         = 100,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pio_button,
    input  logic [1:0] switch,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] digit4,
    output logic [3:0] digit5,
    output logic       running,
    output logic       lap_active
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned DW  = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [1:0] CmdStartStop = 2'b00;
    localparam logic [1:0] CmdLap       = 2'b01;
    localparam logic [1:0] CmdClear     = 2'b10;

    typedef enum logic [1:0] {StIdle, StRun, StPause, StLap} state_e;

    logic          btn_meta, btn_sync;
    logic [1:0]    sw_meta, sw_sync;
    logic          db_level;
    logic [DW-1:0] db_cnt;
    logic          press;
    logic [1:0]    cmd;

    state_e           state_q, state_d;
    logic [5:0][3:0]  cnt_q, cnt_d;
    logic [5:0][3:0]  lap_q, lap_d;
    logic [5:0][3:0]  disp_q, disp_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             counting, tick;

    // Ripple-carry BCD increment; digits 3 and 5 roll over at 5 (seconds/minutes tens).
    function automatic logic [5:0][3:0] bcd_inc(input logic [5:0][3:0] c);
        logic [5:0][3:0] r;
        logic            carry;
        logic [3:0]      lim;
        r     = c;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
            if (carry) begin
                if (c[i] >= lim) begin
                    r[i] = 4'd0;
                end else begin
                    r[i]  = c[i] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Two-flop synchronizers; the button idles released (high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= 1'b1;
            btn_sync <= 1'b1;
            sw_meta  <= 2'b00;
            sw_sync  <= 2'b00;
        end else begin
            btn_meta <= pio_button;
            btn_sync <= btn_meta;
            sw_meta  <= switch;
            sw_sync  <= sw_meta;
        end
    end

    // Debounce: accept a level after DEBOUNCE_CYCLES consecutive differing samples;
    // a 1->0 acceptance emits a one-cycle press with the switch sampled alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_level <= 1'b1;
            db_cnt   <= '0;
            press    <= 1'b0;
            cmd      <= 2'b00;
        end else begin
            press <= 1'b0;
            cmd   <= sw_sync;
            if (btn_sync == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                db_level <= btn_sync;
                db_cnt   <= '0;
                press    <= ~btn_sync;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    // Next state: tick and counter use the pre-transition state, then the command applies.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lap_d    = lap_q;
        presc_d  = presc_q;
        counting = (state_q == StRun) || (state_q == StLap);
        tick     = counting && (presc_q == PW'(DIV - 1));
        if (counting) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
        if (tick) begin
            cnt_d = bcd_inc(cnt_q);
        end
        if (press) begin
            unique case (state_q)
                StIdle: begin
                    if (cmd == CmdStartStop) state_d = StRun;
                end
                StRun: begin
                    if (cmd == CmdStartStop) begin
                        state_d = StPause;
                    end else if (cmd == CmdLap) begin
                        state_d = StLap;
                        lap_d   = cnt_q;
                    end
                end
                StLap: begin
                    if (cmd == CmdStartStop) begin
                        state_d = StPause;
                    end else if (cmd == CmdLap) begin
                        state_d = StRun;
                    end
                end
                StPause: begin
                    if (cmd == CmdStartStop) begin
                        state_d = StRun;
                    end else if (cmd == CmdClear) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        presc_d = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        disp_d = (state_d == StLap) ? lap_d : cnt_d;
    end

    // State, count, lap register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            lap_q      <= '0;
            presc_q    <= '0;
            disp_q     <= '0;
            running    <= 1'b0;
            lap_active <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lap_q      <= lap_d;
            presc_q    <= presc_d;
            disp_q     <= disp_d;
            running    <= (state_d == StRun) || (state_d == StLap);
            lap_active <= (state_d == StLap);
        end
    end

    assign digit0 = disp_q[0];
    assign digit1 = disp_q[1];
    assign digit2 = disp_q[2];
    assign digit3 = disp_q[3];
    assign digit4 = disp_q[4];
    assign digit5 = disp_q[5];

endmodule
